// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer client (master) and countdown_timer (slave).
import countdown_pkg::*;

interface countdown_timer_if #(parameter int WIDTH = DEF_WIDTH);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (output enable, load, load_value, input  out, busy, done);
  modport slave  (input  enable, load, load_value, output out, busy, done);
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to reload from the captured start value.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  state_e           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rel, rel_n;
  logic             done_q, done_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rel    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rel    <= rel_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rel_n   = rel;
    done_n  = 1'b0;
    // Load takes priority over everything, including a coincident terminal count.
    if (bus.load) begin
      cnt_n = bus.load_value;
      rel_n = bus.load_value;
      if (bus.load_value == '0) state_n = IDLE;
      else                      state_n = bus.enable ? RUN : HOLD;
    end else if (state != IDLE) begin
      if (!bus.enable) begin
        state_n = HOLD;
      end else begin
        // HOLD resuming steps on the same edge as RUN does.
        state_n = RUN;
        if (cnt == WIDTH'(1)) begin
          cnt_n  = '0;
          done_n = 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
          state_n = IDLE;
`endif
        end else if (cnt == '0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          cnt_n = rel;
`else
          state_n = IDLE;
`endif
        end else begin
          cnt_n = cnt - WIDTH'(1);
        end
      end
    end
  end

  assign bus.out  = cnt;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with terminal-count pulse, the decrementing counterpart to the team's 4-bit up-counter. Software or an upstream FSM loads a start value; the block counts toward zero while `enable` is high, pauses while it is low, and flags expiry with a one-cycle `done` pulse. It is the standard timeout and delay primitive for control logic in this codebase.

## Interface
- `WIDTH`, 4, counter width in bits (≥2)
- `clock`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `enable`  input  1  count enable; level-sensitive
- `load`  input  1  single-cycle load strobe
- `load_value`  input  WIDTH  start value captured on `load`
- `out`  output  WIDTH  current count, registered
- `busy`  output  1  high whenever state ≠ IDLE, registered
- `done`  output  1  one-cycle terminal-count pulse, registered

## Operation
- States: IDLE, RUN, HOLD.
- Reset (`reset`=0, any time, including mid-count): state IDLE, `out`=0, `busy`=0, `done`=0, reload register=0. Takes effect immediately, without waiting for a clock edge.
- `load`=1 in any state:
  - Next edge: `out`←`load_value`, and the reload register captures `load_value`.
  - If `load_value`=0: state goes to IDLE and no `done` pulse is produced.
  - Otherwise: state goes to RUN if `enable`=1, or to HOLD if `enable`=0.
- RUN with `enable`=1: `out`←`out`−1 each edge.
- RUN with `enable`=0: goes to HOLD; `out` frozen.
- HOLD with `enable`=1: goes to RUN; decrement resumes on the same edge.
- Terminal count: on the edge where `out` goes from 1 to 0, `done`←1 for exactly one cycle. The state then becomes IDLE (see Configuration for auto-reload).
- IDLE ignores `enable`. `out` stays at its value and never underflows; there is no wrap from 0 to 2^WIDTH−1.
- Simultaneous `load` and terminal count: `load` wins, `done` stays 0, and the new value is taken.
- Arithmetic is unsigned and WIDTH-bit. The maximum load is 2^WIDTH−1.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Load latency: `out` shows `load_value` one cycle after the `load` edge.
- A load of N with `enable` held high gives `done` high in the cycle `out`=0, which is N edges after `out`=N.
- `busy` drops on the same edge that `done` rises (non-reload mode).
- `done` is never high for two consecutive cycles.
- Pausing: `enable` low for k cycles delays `done` by exactly k cycles.

## Configuration
- Macro: `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - At terminal count the state stays RUN. `out`=0 is visible for one cycle with `done`=1, then `out`←reload register on the next edge.
  - The period is N+1 cycles per `done` pulse.
  - A reload value of 0 never reaches RUN, so the block cannot free-run at zero.
  - `enable` low at the zero cycle moves to HOLD with `out`=0. The reload then happens on the first edge with `enable`=1.
- Undefined: one-shot behaviour as in Operation. The reload register is still captured but is unused.

## Structure
- Package `countdown_pkg`:
  - state enum {IDLE, RUN, HOLD}
  - default width constant
- Flat module. No sub-module is warranted.
- One state register, one count register, one reload register, one `done` flop.

## Test plan
- Reset with `load`=1, `load_value`=9 held during reset → `out`=0, `busy`=0, `done`=0 throughout reset. Releasing reset mid-count from 5 → still 0 until the next load.
- Load 3, `enable`=1 → `out` goes 3,2,1,0. `done`=1 only in the `out`=0 cycle, `busy` falls on that same edge, and `out` stays 0 afterwards.
- Load 4, `enable` pattern 1,1,0,0,0,1,1 → `out` goes 4,3,2,2,2,2,1,0. `done` is delayed by 3 cycles relative to the no-pause case.
- Load 2 and count; assert `load`=1 with 7 on the 1→0 edge → `out`=7, `done` stays 0, state RUN.
- Load 0 with `enable`=1 → `out`=0, `busy`=0, and no `done` pulse ever.
- With `COUNTDOWN_AUTO_RELOAD_EN`: load 2, `enable`=1 for 12 cycles → `out` cycles 2,1,0,2,1,0,… with `done` high every third cycle. Without the macro, the same stimulus gives a single `done` pulse.
